// File: rtl/axi_stream_pkg.sv
// Shared constants for the core-to-fabric AXI-Stream transmitter.
package axi_stream_pkg;

  localparam int TDEST_W   = 8;
  localparam int TID_W     = 8;
  localparam int PKT_CNT_W = 16;

  // Destination-lock FSM encoding.
  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_IN_PACKET = 1'b1;

  // Width of one buffered beat: {data, keep, last, dest}.
  function automatic int entry_width(input int bus_w);
    return bus_w + bus_w / 8 + 1 + TDEST_W;
  endfunction

endpackage

// File: rtl/axi_stream_sync_fifo.sv
// Single-clock FIFO with registered occupancy and a combinational head read.
module axi_stream_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller does not.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_stream_write_extended.sv
// AXI-Stream master: buffers core beats, locks TDEST per packet, counts packets sent.
//
// Handshakes: on both the core side (i_input_valid/o_input_ready) and the AXI side
// (o_tvalid/i_tready) a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once valid is raised the payload is
// held until that transfer.
module axi_stream_write_extended
  import axi_stream_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_aresetn,
  input  logic [31:0]            i_core_TID,
  input  logic                   i_input_valid,
  output logic                   o_input_ready,
  input  logic [BUS_WIDTH-1:0]   i_data,
  input  logic [BUS_WIDTH/8-1:0] i_tkeep,
  input  logic                   i_tlast,
  input  logic [TDEST_W-1:0]     i_dest,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic [BUS_WIDTH-1:0]   o_tdata,
  output logic [BUS_WIDTH/8-1:0] o_tkeep,
  output logic [TDEST_W-1:0]     o_tdest,
  output logic [TID_W-1:0]       o_tid,
  output logic                   o_tlast,
  output logic [PKT_CNT_W-1:0]   o_packets_sent,
  output logic                   o_busy,
  output logic [0:0]             o_dbg_state
);

  localparam int KEEP_W  = BUS_WIDTH / 8;
  localparam int ENTRY_W = entry_width(BUS_WIDTH);

  logic [0:0]           r_state;
  logic [TDEST_W-1:0]   r_pkt_dest;
  logic                 r_ready_en;
  logic [PKT_CNT_W-1:0] r_pkt_cnt;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [ENTRY_W-1:0]   wdata;
  logic [ENTRY_W-1:0]   rdata;
  logic [TDEST_W-1:0]   entry_dest;

  logic [BUS_WIDTH-1:0] head_data;
  logic [KEEP_W-1:0]    head_keep;
  logic                 head_last;
  logic [TDEST_W-1:0]   head_dest;

  // Only the low byte of the core ID is carried on TID.
  logic unused_tid;
  assign unused_tid = ^i_core_TID[31:TID_W];

  // Ready comes from registered state only, so i_tready never reaches it combinationally.
  assign o_input_ready = r_ready_en && !fifo_full;
  assign push          = i_input_valid && o_input_ready;
  assign pop           = !fifo_empty && i_tready;

  // Beats after the first in a packet reuse the destination latched at packet start.
  assign entry_dest = (r_state == ST_IN_PACKET) ? r_pkt_dest : i_dest;
  assign wdata      = {i_data, i_tkeep, i_tlast, entry_dest};

  axi_stream_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .rdata     (rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_data, head_keep, head_last, head_dest} = rdata;

  assign o_tvalid       = !fifo_empty;
  assign o_tdata        = head_data;
  assign o_tkeep        = head_keep;
  assign o_tlast        = head_last;
  assign o_tdest        = head_dest;
  assign o_tid          = i_core_TID[TID_W-1:0];
  assign o_packets_sent = r_pkt_cnt;
  assign o_busy         = (r_state == ST_IN_PACKET) || !fifo_empty;
  assign o_dbg_state    = r_state;

  // Holds input ready low until the first edge after reset is released.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) r_ready_en <= 1'b0;
    else            r_ready_en <= 1'b1;
  end

  // Destination lock: latch i_dest on a packet's first beat, release on its last.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state    <= ST_IDLE;
      r_pkt_dest <= '0;
    end else if (push) begin
      if (r_state == ST_IDLE) begin
        if (!i_tlast) begin
          r_pkt_dest <= i_dest;
          r_state    <= ST_IN_PACKET;
        end
      end else if (i_tlast) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Count packets whose last beat was accepted downstream; wraps naturally.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)             r_pkt_cnt <= '0;
    else if (pop && head_last)  r_pkt_cnt <= r_pkt_cnt + 1'b1;
  end

endmodule

// File: tb/tb_axi_stream_write_extended.sv
// Directed bench for axi_stream_write_extended: table of single-cycle vectors plus
// hand-written sequences for backpressure, streaming, reset and counter wrap.
module tb_axi_stream_write_extended;

  logic        i_clk;
  logic        i_aresetn;
  logic [31:0] i_core_TID;
  logic        i_input_valid;
  logic        o_input_ready;
  logic [15:0] i_data;
  logic [1:0]  i_tkeep;
  logic        i_tlast;
  logic [7:0]  i_dest;
  logic        o_tvalid;
  logic        i_tready;
  logic [15:0] o_tdata;
  logic [1:0]  o_tkeep;
  logic [7:0]  o_tdest;
  logic [7:0]  o_tid;
  logic        o_tlast;
  logic [15:0] o_packets_sent;
  logic        o_busy;
  logic [0:0]  o_dbg_state;

  axi_stream_write_extended #(.BUS_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .i_clk          (i_clk),
    .i_aresetn      (i_aresetn),
    .i_core_TID     (i_core_TID),
    .i_input_valid  (i_input_valid),
    .o_input_ready  (o_input_ready),
    .i_data         (i_data),
    .i_tkeep        (i_tkeep),
    .i_tlast        (i_tlast),
    .i_dest         (i_dest),
    .o_tvalid       (o_tvalid),
    .i_tready       (i_tready),
    .o_tdata        (o_tdata),
    .o_tkeep        (o_tkeep),
    .o_tdest        (o_tdest),
    .o_tid          (o_tid),
    .o_tlast        (o_tlast),
    .o_packets_sent (o_packets_sent),
    .o_busy         (o_busy),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic        sb_en   = 1'b0;
  int          hs_cnt  = 0;
  int          hs_first = 0;
  int          hs_last  = 0;

  // Inputs are stable between +1 after a rising edge and the next one, so the
  // falling edge sees exactly what the coming rising edge will act on.
  always @(negedge i_clk) begin
    if (sb_en) begin
      if (i_input_valid && o_input_ready) exp_q.push_back(i_data);
      if (o_tvalid && i_tready) begin
        hs_cnt++;
        if (hs_cnt == 1) hs_first = cyc;
        hs_last = cyc;
        check("sb_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_data", 32'(o_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic [7:0]  dest;
    logic        e_vld;
    logic [15:0] e_data;
    logic [1:0]  e_keep;
    logic        e_last;
    logic [7:0]  e_dest;
    logic        e_busy;
    logic        e_state;
    logic [15:0] e_pkts;
  } vec_t;

  vec_t vecs[9];

  initial begin
    i_aresetn     = 1'b0;
    i_core_TID    = 32'h1234_562A;
    i_input_valid = 1'b0;
    i_data        = '0;
    i_tkeep       = '0;
    i_tlast       = 1'b0;
    i_dest        = '0;
    i_tready      = 1'b1;

    //             vld  data      keep   l     dest  | e_vld e_data   e_keep e_l  e_dest busy st   pkts
    vecs[0] = '{1'b1, 16'hBEEF, 2'b11, 1'b1, 8'h05, 1'b1, 16'hBEEF, 2'b11, 1'b1, 8'h05, 1'b1, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};
    vecs[2] = '{1'b1, 16'h1111, 2'b01, 1'b0, 8'h03, 1'b1, 16'h1111, 2'b01, 1'b0, 8'h03, 1'b1, 1'b1, 16'd1};
    vecs[3] = '{1'b1, 16'h2222, 2'b10, 1'b0, 8'h07, 1'b1, 16'h2222, 2'b10, 1'b0, 8'h03, 1'b1, 1'b1, 16'd1};
    vecs[4] = '{1'b1, 16'h3333, 2'b11, 1'b0, 8'h09, 1'b1, 16'h3333, 2'b11, 1'b0, 8'h03, 1'b1, 1'b1, 16'd1};
    vecs[5] = '{1'b1, 16'h4444, 2'b01, 1'b1, 8'h0B, 1'b1, 16'h4444, 2'b01, 1'b1, 8'h03, 1'b1, 1'b0, 16'd1};
    vecs[6] = '{1'b0, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2};
    vecs[7] = '{1'b1, 16'h5555, 2'b10, 1'b1, 8'h0C, 1'b1, 16'h5555, 2'b10, 1'b1, 8'h0C, 1'b1, 1'b0, 16'd2};
    vecs[8] = '{1'b0, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 16'd3};

    // ---- reset values ----
    #12;
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tdata",  32'(o_tdata),  32'd0);
    check("rst_tkeep",  32'(o_tkeep),  32'd0);
    check("rst_tdest",  32'(o_tdest),  32'd0);
    check("rst_tlast",  32'(o_tlast),  32'd0);
    check("rst_pkts",   32'(o_packets_sent), 32'd0);
    check("rst_busy",   32'(o_busy),   32'd0);
    check("rst_ready",  32'(o_input_ready), 32'd0);
    check("rst_state",  32'(o_dbg_state), 32'd0);
    i_aresetn = 1'b1;
    step();
    check("post_rst_ready", 32'(o_input_ready), 32'd1);

    // ---- table: single beat, then 4-beat packet with changing i_dest ----
    for (int i = 0; i < 9; i++) begin
      i_input_valid = vecs[i].vld;
      i_data        = vecs[i].data;
      i_tkeep       = vecs[i].keep;
      i_tlast       = vecs[i].last;
      i_dest        = vecs[i].dest;
      step();
      check($sformatf("t%0d_tvalid", i), 32'(o_tvalid), 32'(vecs[i].e_vld));
      check($sformatf("t%0d_ready", i),  32'(o_input_ready), 32'd1);
      check($sformatf("t%0d_busy", i),   32'(o_busy), 32'(vecs[i].e_busy));
      check($sformatf("t%0d_state", i),  32'(o_dbg_state), 32'(vecs[i].e_state));
      check($sformatf("t%0d_pkts", i),   32'(o_packets_sent), 32'(vecs[i].e_pkts));
      check($sformatf("t%0d_tid", i),    32'(o_tid), 32'h2A);
      if (vecs[i].e_vld) begin
        check($sformatf("t%0d_tdata", i), 32'(o_tdata), 32'(vecs[i].e_data));
        check($sformatf("t%0d_tkeep", i), 32'(o_tkeep), 32'(vecs[i].e_keep));
        check($sformatf("t%0d_tlast", i), 32'(o_tlast), 32'(vecs[i].e_last));
        check($sformatf("t%0d_tdest", i), 32'(o_tdest), 32'(vecs[i].e_dest));
      end
    end
    i_input_valid = 1'b0;

    // ---- backpressure: fill with i_tready low, then drain ----
    sb_en    = 1'b1;
    hs_cnt   = 0;
    i_tready = 1'b0;
    i_tkeep  = 2'b11;
    i_tlast  = 1'b0;
    i_dest   = 8'h21;
    i_input_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = 16'hD000 + 16'(i);
      step();
      check($sformatf("bp_ready_%0d", i), 32'(o_input_ready), (i < 3) ? 32'd1 : 32'd0);
      check($sformatf("bp_tvalid_%0d", i), 32'(o_tvalid), 32'd1);
      check($sformatf("bp_tdata_%0d", i), 32'(o_tdata), 32'hD000);
    end
    i_data = 16'hD004;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("bp_full_ready_%0d", i), 32'(o_input_ready), 32'd0);
      check($sformatf("bp_hold_tdata_%0d", i), 32'(o_tdata), 32'hD000);
    end
    i_tready = 1'b1;
    step();
    check("bp_ready_after_pop", 32'(o_input_ready), 32'd1);
    check("bp_head_after_pop",  32'(o_tdata), 32'hD001);
    step();
    i_input_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_hs_cnt",  32'(hs_cnt), 32'd5);
    check("bp_tvalid_empty", 32'(o_tvalid), 32'd0);

    // ---- back-to-back streaming ----
    hs_cnt = 0;
    i_input_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      i_data = 16'h0100 + 16'(i);
      step();
    end
    i_input_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("str_hs_cnt",  32'(hs_cnt), 32'd32);
    check("str_no_gaps", 32'(hs_last - hs_first), 32'd31);
    check("str_drained", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b0;

    // ---- asynchronous reset mid-packet ----
    i_tready = 1'b0;
    i_input_valid = 1'b1;
    i_tlast = 1'b0;
    i_dest  = 8'h0A;
    i_data  = 16'hAAAA;
    step();
    i_data  = 16'hBBBB;
    step();
    i_input_valid = 1'b0;
    check("ar_pre_tvalid", 32'(o_tvalid), 32'd1);
    check("ar_pre_state",  32'(o_dbg_state), 32'd1);
    #2;
    i_aresetn = 1'b0;
    #1;
    check("ar_tvalid", 32'(o_tvalid), 32'd0);
    check("ar_ready",  32'(o_input_ready), 32'd0);
    check("ar_busy",   32'(o_busy), 32'd0);
    check("ar_state",  32'(o_dbg_state), 32'd0);
    check("ar_pkts",   32'(o_packets_sent), 32'd0);
    #2;
    i_aresetn = 1'b1;
    step();
    check("ar_ready_rel", 32'(o_input_ready), 32'd1);
    check("ar_tvalid_rel", 32'(o_tvalid), 32'd0);
    i_tready = 1'b1;
    i_input_valid = 1'b1;
    i_data  = 16'hCAFE;
    i_tkeep = 2'b11;
    i_tlast = 1'b1;
    i_dest  = 8'h0C;
    step();
    i_input_valid = 1'b0;
    check("ar_new_tvalid", 32'(o_tvalid), 32'd1);
    check("ar_new_tdata",  32'(o_tdata), 32'hCAFE);
    check("ar_new_tdest",  32'(o_tdest), 32'h0C);
    check("ar_new_tlast",  32'(o_tlast), 32'd1);
    step();
    check("ar_new_pkts",   32'(o_packets_sent), 32'd1);

    // ---- packet counter wrap ----
    i_input_valid = 1'b1;
    i_tlast = 1'b1;
    i_dest  = 8'h01;
    for (int i = 0; i < 65534; i++) begin
      i_data = 16'(i);
      step();
    end
    i_input_valid = 1'b0;
    step();
    step();
    check("wrap_pre", 32'(o_packets_sent), 32'hFFFF);
    i_input_valid = 1'b1;
    step();
    i_input_valid = 1'b0;
    step();
    step();
    check("wrap_post", 32'(o_packets_sent), 32'h0000);
    check("wrap_busy", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_stream_write_extended.md
Name: axi_stream_write_extended

Overview:
- AXI-Stream transmitter (master side) for the core-to-fabric path; mirror of the core-side stream receiver.
- Accepts beats from a local core over a valid/ready interface. Each beat carries data, keep, last and a destination ID.
- Buffers beats in a small FIFO and drives them onto an AXI-Stream master port with TDEST/TID, at full throughput.
- Locks TDEST for the whole packet and counts packets sent.

Parameters:
- BUS_WIDTH, 16, TDATA width in bits; multiple of 8.
- FIFO_DEPTH, 4, buffer entries; power of two, >= 2.
- PTR_W, $clog2(FIFO_DEPTH), pointer width (derived, not overridden).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_aresetn  in  1  asynchronous reset, active low.
- i_core_TID  in  32  this core's ID; bits [7:0] drive o_tid.
- i_input_valid  in  1  core beat valid.
- o_input_ready  out  1  block can accept a beat.
- i_data  in  BUS_WIDTH  beat data.
- i_tkeep  in  BUS_WIDTH/8  beat byte enables.
- i_tlast  in  1  last beat of packet.
- i_dest  in  8  destination ID; sampled on the first beat of a packet only.
- o_tvalid  out  1  AXI TVALID.
- i_tready  in  1  AXI TREADY.
- o_tdata  out  BUS_WIDTH  AXI TDATA.
- o_tkeep  out  BUS_WIDTH/8  AXI TKEEP.
- o_tdest  out  8  AXI TDEST.
- o_tid  out  8  AXI TID.
- o_tlast  out  1  AXI TLAST.
- o_packets_sent  out  16  count of TLAST beats accepted downstream; wraps.
- o_busy  out  1  high while in IN_PACKET or FIFO non-empty.

Behaviour:
- Reset (async assert, sync release) values:
  - o_tvalid=0, o_tdata=0, o_tkeep=0, o_tdest=0, o_tlast=0, o_packets_sent=0, o_busy=0.
  - o_input_ready=1 after reset; 0 while i_aresetn low.
  - FIFO emptied; FSM in IDLE.
- Input handshake:
  - Push occurs when i_input_valid && o_input_ready at a rising edge.
  - o_input_ready = !full, decoded from registered occupancy only; no combinational path from i_tready.
- FIFO entry contents: {data, keep, last, dest}.
- Destination lock FSM, states IDLE and IN_PACKET:
  - IDLE, push with i_tlast=0: store i_dest, latch it into r_pkt_dest, go to IN_PACKET.
  - IDLE, push with i_tlast=1: single-beat packet; store i_dest; stay IDLE.
  - IN_PACKET, any push: store r_pkt_dest (i_dest ignored).
  - IN_PACKET, push with i_tlast=1: go to IDLE.
- Output:
  - o_tvalid = FIFO non-empty. o_tdata/o_tkeep/o_tlast/o_tdest are the head entry.
  - o_tid = i_core_TID[7:0], held constant (not stored per entry).
  - Once o_tvalid is high, outputs are stable until i_tready. o_tvalid never drops without a handshake (AXI rule).
- Pop occurs on o_tvalid && i_tready.
- Latency: a beat pushed at edge N is visible on o_tvalid after edge N (one cycle), when the FIFO was empty.
- Throughput: one beat per cycle sustained when i_tready is held high.
- Simultaneous push and pop:
  - Occupancy unchanged; both pointers advance.
  - When full, push is blocked because ready is low, even if a pop occurs that cycle. Ready rises the following cycle.
- Empty with pop: impossible, since o_tvalid=0.
- Full: o_input_ready=0; i_input_valid is ignored; no data loss.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is PTR_W+1.
- o_packets_sent increments by 1 on each pop with tlast=1. It wraps 0xFFFF -> 0x0000.
- Reset mid-packet discards all buffered beats and returns the FSM to IDLE. The next accepted beat is treated as a packet start.
- i_tkeep is passed through unmodified; no null-beat filtering.

Decomposition:
- Shared package axi_stream_pkg:
  - TDEST_W=8, TID_W=8, PKT_CNT_W=16.
  - FSM state encoding: IDLE=1'b0, IN_PACKET=1'b1.
- One sub-module: axi_stream_sync_fifo.
  - Parameters WIDTH, DEPTH; ports i_clk, i_aresetn, push, pop, wdata, rdata, full, empty.
  - Instantiated with WIDTH = BUS_WIDTH + BUS_WIDTH/8 + 1 + 8.
  - The top level holds the FSM, dest lock, counter and output mapping.

Test Plan:
1. Reset, then one beat with data=0xBEEF, keep=2'b11, last=1, dest=0x05, i_core_TID=0x2A, i_tready=1 -> o_tvalid high one cycle later with tdata=0xBEEF, tdest=0x05, tid=0x2A, tlast=1; o_packets_sent=1.
2. 4-beat packet with i_dest changing 0x03,0x07,0x09,0x0B per beat -> all four output beats have tdest=0x03; only beat 4 has tlast=1.
3. i_tready=0 while pushing 5 beats -> o_input_ready falls after 4 pushes; o_tvalid/o_tdata stay stable. Release i_tready -> 4 beats drain in order, and ready rises the cycle after the first pop.
4. i_tready=1 and i_input_valid=1 for 32 back-to-back beats -> 32 output handshakes in 32 consecutive cycles, no bubbles, data in order.
5. Assert i_aresetn=0 mid-packet with 2 beats buffered -> o_tvalid=0 immediately (async). After release, the next beat with dest=0x0C outputs tdest=0x0C.
6. Preload o_packets_sent to 0xFFFF via 65535 single-beat packets, then send one more -> counter reads 0x0000.
